// File: rtl/rx_bytes_des_pkg.sv
// Shared definitions for the CDBUS byte receiver: FSM encoding, header
// offsets, frame limits and the CRC-16/Modbus constants.
package rx_bytes_des_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BITS  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } rx_state_t;

    localparam logic [8:0] HDR_SRC = 9'd0;
    localparam logic [8:0] HDR_DST = 9'd1;
    localparam logic [8:0] HDR_LEN = 9'd2;

    localparam logic [7:0] MAX_DATA_LEN = 8'd253;
    localparam logic [7:0] BCAST_ADDR   = 8'hFF;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    // Index of the last byte of a frame (crc_hi): src, dst, len, data[len], crc_lo, crc_hi.
    function automatic logic [8:0] last_index(input logic [7:0] len);
        return {1'b0, len} + 9'd4;
    endfunction

endpackage

// File: rtl/rx_bytes_des_serial_crc.sv
// Bit-serial CRC-16/Modbus (reflected 0xA001, init 0xFFFF); one data bit per
// data_clk strobe, LSB first. A frame with its own CRC appended leaves 0x0000.
module serial_crc
    import rx_bytes_des_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clean,
    input  logic        data_clk,
    input  logic        data_in,
    output logic [15:0] crc_out
);

    logic feedback;

    assign feedback = crc_out[0] ^ data_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_out <= CRC_INIT;
        end else if (clean) begin
            crc_out <= CRC_INIT;
        end else if (data_clk) begin
            crc_out <= (crc_out >> 1) ^ (feedback ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/rx_bytes_des.sv
// CDBUS serial-to-byte receiver: low-speed first byte, high-speed remainder,
// RAM write-out, CRC check and tx_permit. Optional dst filter: CDBUS_RX_FILTER_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | bus between frames; waits for a start-bit falling edge
//   ST_START | start bit; mid-bit sample rejects glitches
//   ST_BITS  | 8 data bits, LSB first, each fed to the CRC
//   ST_STOP  | stop bit; a 1 delivers the byte
//   ST_GAP   | between bytes of a frame; times out after IDLE_HS_BITS bits
module rx_bytes_des
    import rx_bytes_des_pkg::*;
#(
    parameter int unsigned IDLE_HS_BITS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] div_ls,
    input  logic [15:0] div_hs,
    input  logic [7:0]  idle_wait_len,
    input  logic        user_crc,
    input  logic [7:0]  filter,
    input  logic        abort,
    input  logic        rx,
    input  logic        ram_full,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        wr_done,
    output logic        crc_err,
    output logic        rx_error,
    output logic        lost,
    output logic        tx_permit
);

    localparam logic [15:0] GAP_LOAD = 16'(IDLE_HS_BITS);

    rx_state_t   state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        rx_fall;
    logic [15:0] div_cnt;
    logic [15:0] div_cur;
    logic [15:0] div_sel;
    logic        hs_mode;
    logic        sample;
    logic        wrap;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [8:0]  byte_cnt;
    logic [7:0]  len;
    logic        drop;
    logic        skip;
    logic [15:0] gap_cnt;
    logic        pend_done;
    logic        pend_crc;
    logic        pend_lost;
    logic        is_last;
    logic        dst_reject;
    logic [15:0] crc_val;
    logic        crc_clean;
    logic        crc_strobe;
    logic [15:0] idle_div;
    logic [7:0]  idle_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall    = rx_prev & ~rx_sync;
    assign div_sel    = hs_mode ? div_hs : div_ls;
    assign sample     = (div_cnt == (div_cur >> 1));
    assign wrap       = (div_cnt == div_cur);
    assign is_last    = (byte_cnt == last_index(len));
    assign crc_clean  = (state == ST_IDLE);
    assign crc_strobe = (state == ST_BITS) && sample;

`ifdef CDBUS_RX_FILTER_EN
    assign dst_reject = (byte_cnt == HDR_DST) && (shift != filter) && (shift != BCAST_ADDR);
`else
    logic filter_unused;
    assign filter_unused = ^filter;
    assign dst_reject    = 1'b0;
`endif

    serial_crc u_crc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clean    (crc_clean),
        .data_clk (crc_strobe),
        .data_in  (rx_sync),
        .crc_out  (crc_val)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            div_cnt   <= 16'd0;
            div_cur   <= 16'd0;
            hs_mode   <= 1'b0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            byte_cnt  <= 9'd0;
            len       <= 8'd0;
            drop      <= 1'b0;
            skip      <= 1'b0;
            gap_cnt   <= 16'd0;
            pend_done <= 1'b0;
            pend_crc  <= 1'b0;
            pend_lost <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 8'd0;
            wr_en     <= 1'b0;
            wr_done   <= 1'b0;
            crc_err   <= 1'b0;
            rx_error  <= 1'b0;
            lost      <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            wr_done   <= 1'b0;
            crc_err   <= 1'b0;
            rx_error  <= 1'b0;
            lost      <= 1'b0;
            pend_done <= 1'b0;
            pend_crc  <= 1'b0;
            pend_lost <= 1'b0;

            if (abort) begin
                state    <= ST_IDLE;
                div_cnt  <= 16'd0;
                hs_mode  <= 1'b0;
                byte_cnt <= 9'd0;
                len      <= 8'd0;
                drop     <= 1'b0;
                skip     <= 1'b0;
            end else begin
                // End-of-frame pulses trail the final wr_en by exactly one cycle.
                wr_done <= pend_done;
                crc_err <= pend_crc;
                lost    <= pend_lost;

                if (wrap) begin
                    div_cnt <= 16'd0;
                    div_cur <= div_sel;
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end

                case (state)
                    ST_IDLE: begin
                        div_cnt  <= 16'd0;
                        hs_mode  <= 1'b0;
                        byte_cnt <= 9'd0;
                        len      <= 8'd0;
                        skip     <= 1'b0;
                        drop     <= 1'b0;
                        if (rx_fall) begin
                            state   <= ST_START;
                            div_cur <= div_ls;
                            drop    <= ram_full;
                        end
                    end
                    ST_START: begin
                        if (sample) begin
                            if (!rx_sync) begin
                                state   <= ST_BITS;
                                bit_idx <= 3'd0;
                            end else if (byte_cnt == 9'd0) begin
                                state <= ST_IDLE;
                            end else begin
                                state   <= ST_GAP;
                                div_cnt <= 16'd0;
                                gap_cnt <= GAP_LOAD;
                            end
                        end
                    end
                    ST_BITS: begin
                        if (sample) begin
                            shift   <= {rx_sync, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (sample) begin
                            if (!rx_sync) begin
                                rx_error <= 1'b1;
                                state    <= ST_IDLE;
                            end else if (byte_cnt == HDR_LEN && shift > MAX_DATA_LEN) begin
                                rx_error <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                hs_mode  <= 1'b1;
                                wr_en    <= ~drop & ~skip;
                                wr_addr  <= byte_cnt[7:0];
                                wr_data  <= shift;
                                byte_cnt <= byte_cnt + 9'd1;
                                if (byte_cnt == HDR_LEN) begin
                                    len <= shift;
                                end
                                if (dst_reject) begin
                                    skip <= 1'b1;
                                end
                                if (is_last) begin
                                    state <= ST_IDLE;
                                    if (skip) begin
                                        pend_lost <= 1'b0;
                                    end else if (drop) begin
                                        pend_lost <= 1'b1;
                                    end else if (crc_val == 16'h0000 || user_crc) begin
                                        pend_done <= 1'b1;
                                    end else begin
                                        pend_crc <= 1'b1;
                                    end
                                end else begin
                                    state   <= ST_GAP;
                                    div_cnt <= 16'd0;
                                    div_cur <= div_hs;
                                    gap_cnt <= GAP_LOAD;
                                end
                            end
                        end
                    end
                    ST_GAP: begin
                        if (rx_fall) begin
                            state   <= ST_START;
                            div_cnt <= 16'd0;
                            div_cur <= div_hs;
                        end else if (wrap) begin
                            if (gap_cnt <= 16'd1) begin
                                rx_error <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                gap_cnt <= gap_cnt - 16'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // rx_meta is used for the clear so tx_permit drops two cycles after rx falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_div  <= 16'd0;
            idle_bits <= 8'd0;
            tx_permit <= 1'b0;
        end else if (state != ST_IDLE || !rx_meta || !rx_sync) begin
            idle_div  <= 16'd0;
            idle_bits <= 8'd0;
            tx_permit <= 1'b0;
        end else if (idle_bits >= idle_wait_len) begin
            tx_permit <= 1'b1;
        end else if (idle_div == div_ls) begin
            idle_div  <= 16'd0;
            idle_bits <= idle_bits + 8'd1;
        end else begin
            idle_div <= idle_div + 16'd1;
        end
    end

endmodule
